// File: rtl/audio_pkg.sv
// Shared audio definitions for the attenuator scheduler: default widths, unity gain,
// scheduler state encoding and the channel-index width helper.
package audio_pkg;

  localparam int unsigned BITSIZE_DEF = 16;
  localparam logic [15:0] UNITY_GAIN  = 16'h7FFF;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } sched_state_e;

  // Never narrower than one bit, so a tag register always exists.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/attenuator_scheduler_if.sv
// Bus between the scheduler, its gain and sample sources, and the shared attenuator.
// The master side drives frame inputs and the attenuator product; the slave is the scheduler.
interface attenuator_scheduler_if
  import audio_pkg::*;
#(
  parameter int unsigned BITSIZE = BITSIZE_DEF,
  parameter int unsigned N_CH    = 4
);

  logic                      lrclk;
  logic [N_CH*BITSIZE-1:0]   in_flat;
  logic [N_CH*BITSIZE-1:0]   gain_flat;
  logic [BITSIZE-1:0]        mult_a;
  logic [BITSIZE-1:0]        mult_b;
  logic [BITSIZE-1:0]        mult_p;
  logic [N_CH*BITSIZE-1:0]   out_flat;
  logic                      done;
  logic                      busy;
  logic                      overrun;

  modport master (
    output lrclk, in_flat, gain_flat, mult_p,
    input  mult_a, mult_b, out_flat, done, busy, overrun
  );

  modport slave (
    input  lrclk, in_flat, gain_flat, mult_p,
    output mult_a, mult_b, out_flat, done, busy, overrun
  );

endinterface

// File: rtl/tag_delay_line.sv
// Valid+tag shift register that tracks which channel's product is emerging from the
// attenuator pipeline; synchronous clear drops everything in flight.
module tag_delay_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned TAG_W = 2
) (
  input  logic             i_clk,
  input  logic             i_clr,
  input  logic             i_valid,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  output logic [TAG_W-1:0] o_tag
);

  logic             r_valid [DEPTH];
  logic [TAG_W-1:0] r_tag   [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_valid[i] <= 1'b0;
        r_tag[i]   <= '0;
      end
    end else begin
      r_valid[0] <= i_valid;
      r_tag[0]   <= i_tag;
      for (int i = 1; i < int'(DEPTH); i++) begin
        r_valid[i] <= r_valid[i-1];
        r_tag[i]   <= r_tag[i-1];
      end
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_tag   = r_tag[DEPTH-1];

endmodule

// File: rtl/attenuator_scheduler.sv
// Shares one attenuator multiplier across N_CH channels per audio frame: snapshot on the
// lrclk rising edge, issue one channel per bclk, gather products by tag, publish atomically.
module attenuator_scheduler
  import audio_pkg::*;
#(
  parameter int unsigned BITSIZE      = BITSIZE_DEF,
  parameter int unsigned N_CH         = 4,
  parameter int unsigned MULT_LATENCY = 1
) (
  input logic                    i_bclk,
  input logic                    i_rst,
  attenuator_scheduler_if.slave  bus
);

  localparam int unsigned IDX_W = idx_width(N_CH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

  sched_state_e       r_state;
  sched_state_e       w_state_next;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   w_idx_next;
  logic               r_lrclk_q;
  logic               w_frame_start;
  logic               w_issue;
  logic               w_cap_valid;
  logic [IDX_W-1:0]   w_cap_tag;
  logic               w_publish;

  logic [BITSIZE-1:0]        r_in_snap   [N_CH];
  logic [BITSIZE-1:0]        r_gain_snap [N_CH];
  logic [BITSIZE-1:0]        r_shadow    [N_CH];
  logic [BITSIZE-1:0]        r_mult_a;
  logic [BITSIZE-1:0]        r_mult_b;
  logic [N_CH*BITSIZE-1:0]   r_out;
  logic                      r_done;
  logic                      r_overrun;

  assign w_frame_start = bus.lrclk & ~r_lrclk_q;
  assign w_issue       = (r_state == ISSUE);
  // The last channel's product arriving is the publish point for the whole frame.
  assign w_publish     = w_cap_valid && (w_cap_tag == LAST_IDX);

  tag_delay_line #(
    .DEPTH (MULT_LATENCY),
    .TAG_W (IDX_W)
  ) u_tag_delay_line (
    .i_clk   (i_bclk),
    .i_clr   (i_rst),
    .i_valid (w_issue),
    .i_tag   (r_idx),
    .o_valid (w_cap_valid),
    .o_tag   (w_cap_tag)
  );

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    unique case (r_state)
      IDLE: begin
        if (w_frame_start) begin
          w_state_next = ISSUE;
          w_idx_next   = '0;
        end
      end
      ISSUE: begin
        if (r_idx == LAST_IDX) begin
          w_state_next = DRAIN;
          w_idx_next   = '0;
        end else begin
          w_idx_next = r_idx + 1'b1;
        end
      end
      DRAIN: begin
        if (w_publish) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_idx_next   = '0;
      end
    endcase
  end

  always_ff @(posedge i_bclk) begin
    // Tracks lrclk even in reset so a high lrclk at release is not seen as a new frame.
    r_lrclk_q <= bus.lrclk;
    if (i_rst) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_mult_a  <= '0;
      r_mult_b  <= '0;
      r_out     <= '0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
      for (int k = 0; k < int'(N_CH); k++) begin
        r_in_snap[k]   <= '0;
        r_gain_snap[k] <= '0;
        r_shadow[k]    <= '0;
      end
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
      r_done  <= w_publish;

      if (w_frame_start && (r_state != IDLE)) begin
        r_overrun <= 1'b1;
      end

      if ((r_state == IDLE) && w_frame_start) begin
        for (int k = 0; k < int'(N_CH); k++) begin
          r_in_snap[k]   <= bus.in_flat[k*BITSIZE +: BITSIZE];
          r_gain_snap[k] <= bus.gain_flat[k*BITSIZE +: BITSIZE];
        end
      end

      if (w_issue) begin
        r_mult_a <= r_in_snap[r_idx];
        r_mult_b <= r_gain_snap[r_idx];
      end

      if (w_cap_valid) begin
        r_shadow[w_cap_tag] <= bus.mult_p;
      end

      // Last channel bypasses the shadow so the frame lands on its capture edge.
      if (w_publish) begin
        for (int k = 0; k < int'(N_CH); k++) begin
          if (k == int'(N_CH) - 1) begin
            r_out[k*BITSIZE +: BITSIZE] <= bus.mult_p;
          end else begin
            r_out[k*BITSIZE +: BITSIZE] <= r_shadow[k];
          end
        end
      end
    end
  end

  assign bus.mult_a   = r_mult_a;
  assign bus.mult_b   = r_mult_b;
  assign bus.out_flat = r_out;
  assign bus.done     = r_done;
  assign bus.busy     = (r_state != IDLE);
  assign bus.overrun  = r_overrun;

endmodule

// File: doc/attenuator_scheduler.md
Name: attenuator_scheduler

Overview:
Time-multiplexes one shared attenuator multiplier across N_CH audio channels inside each sample frame. At each lrclk rising edge it snapshots all channel samples and gains, then issues one channel per bclk into the attenuator. It collects the pipelined products by tag and publishes all channel results atomically with a one-cycle done pulse. Sits between the per-channel gain sources (mixer, compressor gain logic) and a single attenuator instance, replacing one multiplier per channel.

Parameters:
BITSIZE, 16, sample and gain width.
N_CH, 4, number of channels sharing the multiplier (2..16).
MULT_LATENCY, 1, attenuator input-to-output latency in bclk cycles (1..4).

Ports:
bclk  in  1  audio bit clock; sole clock.
rst  in  1  synchronous, active-high reset.
lrclk  in  1  frame clock; a rising edge starts a frame.
in_flat  in  N_CH*BITSIZE  signed samples; channel k at bits [k*BITSIZE +: BITSIZE].
gain_flat  in  N_CH*BITSIZE  unsigned Q1.15 gains; 0x7FFF is approximately unity.
mult_a  out  BITSIZE  signed sample to the attenuator `in`.
mult_b  out  BITSIZE  gain to the attenuator `att`.
mult_p  in  BITSIZE  signed attenuator `out`, valid MULT_LATENCY cycles after issue.
out_flat  out  N_CH*BITSIZE  signed attenuated samples, same packing as in_flat.
done  out  1  one-cycle pulse; out_flat updated on the same edge.
busy  out  1  high while a frame is in progress.
overrun  out  1  sticky; a frame start arrived while busy.

Behaviour:
- Reset: all outputs are 0, state is IDLE, tag pipeline is cleared. Reset mid-frame aborts the frame. The shadow register is discarded and out_flat keeps 0.
- Frame detect: lrclk is registered into lrclk_q. Edge E is the bclk edge where lrclk=1 and lrclk_q=0.
- States: IDLE, ISSUE, DRAIN.
- IDLE: at edge E, snapshot in_flat and gain_flat, set issue index to 0, set busy=1, go to ISSUE.
- ISSUE: at edge E+1+k, drive mult_a and mult_b for channel k and push valid with tag k into the delay line (depth MULT_LATENCY). After k=N_CH-1, go to DRAIN.
- DRAIN: wait until the delay line is empty, then return to IDLE.
- Capture: when delay-line valid is set, write mult_p into shadow[tag]. Capture for channel k happens at edge E+1+k+MULT_LATENCY.
- Publish: on the edge that captures tag N_CH-1, which is edge E+N_CH+MULT_LATENCY:
  - copy shadow into out_flat, with channel N_CH-1 taken directly from mult_p;
  - assert done for exactly that cycle;
  - clear busy.
  Total frame latency is N_CH+MULT_LATENCY cycles. out_flat never shows a partial frame.
- mult_a and mult_b hold their last issued values when idle. They do not return to zero.
- Input changes after edge E have no effect on the current frame.
- Frame start while busy (E during ISSUE or DRAIN): the frame is ignored, the current frame completes normally, and overrun is set. overrun clears only on rst.
- Frame start on the same edge as publish: busy is still 1 on that edge, so the start is ignored and overrun is set.
- Arithmetic: the scheduler performs none. Products are passed through bit-exact from mult_p.

Decomposition:
- Shared package audio_pkg holds:
  - BITSIZE default;
  - UNITY_GAIN = 16'h7FFF;
  - the state encoding enum {IDLE, ISSUE, DRAIN};
  - index width as clog2(N_CH).
- One natural sub-module, tag_delay_line: a parameterised valid+tag shift register of depth MULT_LATENCY with synchronous clear.

Test Plan:
- Basic frame (N_CH=4, MULT_LATENCY=1, bench attenuator model p=(a*b)>>>15): in={1000,-1000,12345,-32768}, gain={0x7FFF,0x4000,0x0000,0x2000} -> out_flat={999,-500,0,-8192}, done at E+5, busy high for E+1..E+4.
- Atomicity: a second frame with new inputs -> out_flat holds the previous frame's values until the done edge, then all four channels change on that single edge.
- Mid-frame input change: in_flat changes at E+2 -> results match the snapshot taken at E.
- Overrun: a second lrclk rising edge at E+3 -> no restart, done still at E+5, overrun=1 until rst.
- Reset mid-frame: rst at E+2 -> done never pulses, out_flat=0, busy=0, and the next frame behaves like the basic case.
- MULT_LATENCY=3, N_CH=2: in={-32768,32767}, gain=0x7FFF for both -> out_flat={-32767,32766}, done at E+5.
